// File: rtl/fifo_wptr_full_if.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full_if
// Write-side bus of the dual-clock FIFO pointer/flag controller.
//
// Signals:
//   winc          producer write request
//   wq2_rptr      Gray read pointer as seen by the write domain
//   wovf_clr      clears the sticky overflow flag
//   w_addr        memory write address
//   wclken        memory write enable
//   wptr          registered Gray write pointer, to the read-domain synchronizer
//   wfull         registered full flag
//   walmost_full  registered almost-full flag
//   wlevel        registered fill level, 0..2**Addr_Width
//   woverflow     sticky overflow flag
//
// Modports:
//   master  producer / integrator side (drives requests, observes status)
//   slave   fifo_wptr_full itself
// ---------------------------------------------------------------------------
interface fifo_wptr_full_if #(
  parameter int Addr_Width = 4
);
  logic                  winc;
  logic [Addr_Width:0]   wq2_rptr;
  logic                  wovf_clr;
  logic [Addr_Width-1:0] w_addr;
  logic                  wclken;
  logic [Addr_Width:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [Addr_Width:0]   wlevel;
  logic                  woverflow;

  modport master (
    output winc, wq2_rptr, wovf_clr,
    input  w_addr, wclken, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wovf_clr,
    output w_addr, wclken, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
// Write-side pointer and full-flag controller of the dual-clock FIFO. Runs
// entirely in the wclk domain: drives the memory write address/enable, keeps
// the binary and Gray write pointers, and compares against the synchronized
// Gray read pointer to produce full, almost-full, fill level and a sticky
// overflow flag.
//
// Parameters:
//   Addr_Width  memory address width, depth = 2**Addr_Width (>= 2)
//   AF_Thresh   fill level at or above which walmost_full asserts
//
// Ports:
//   wclk    write-domain clock
//   wrst_n  asynchronous active-low reset, write domain
//   bus     fifo_wptr_full_if.slave (winc, wq2_rptr, wovf_clr in;
//           w_addr, wclken, wptr, wfull, walmost_full, wlevel, woverflow out)
//
// Build option:
//   FIFO_WSYNC_EN  when defined, wq2_rptr carries the raw rclk-domain Gray
//                  read pointer and a 2-flop synchronizer is built in here.
// ---------------------------------------------------------------------------
module fifo_wptr_full #(
  parameter int Addr_Width = 4,
  parameter int AF_Thresh  = 12
) (
  input logic              wclk,
  input logic              wrst_n,
  fifo_wptr_full_if.slave  bus
);
  localparam int AW = Addr_Width;
  localparam logic [AW:0] AfLevel = (AW+1)'(AF_Thresh);

  logic [AW:0] wbin;
  logic [AW:0] wgray;
  logic        full_q;
  logic        afull_q;
  logic [AW:0] level_q;
  logic        ovf_q;

  logic [AW:0] rptr_sync;
  logic [AW:0] rbin_sync;
  logic [AW:0] full_cmp;
  logic        wclken_i;
  logic [AW:0] wbin_next;
  logic [AW:0] wgray_next;
  logic [AW:0] level_next;

`ifdef FIFO_WSYNC_EN
  logic [AW:0] rsync1;
  logic [AW:0] rsync2;

  // Two-flop synchronizer for the raw read-domain Gray pointer.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rsync1 <= '0;
      rsync2 <= '0;
    end else begin
      rsync1 <= bus.wq2_rptr;
      rsync2 <= rsync1;
    end
  end

  assign rptr_sync = rsync2;
`else
  assign rptr_sync = bus.wq2_rptr;
`endif

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= AW; i++) begin
      rbin_sync[i] = ^(rptr_sync >> i);
    end
  end

  // The write pointer is full when it is exactly one lap ahead of the read
  // pointer: in Gray code that means the top two bits inverted, rest equal.
  assign full_cmp = {~rptr_sync[AW:AW-1], rptr_sync[AW-2:0]};

  // Gated by reset as well so the memory never sees a write while the
  // controller is being held in reset.
  assign wclken_i   = bus.winc & ~full_q & wrst_n;
  assign wbin_next  = wbin + {{AW{1'b0}}, wclken_i};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign level_next = wbin_next - rbin_sync;

  // Flags are computed from the next pointer so they change on the same edge
  // that performs the write. A read seen through the synchronizer can only
  // lower them one edge after it arrives, which keeps full pessimistic.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin    <= '0;
      wgray   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wgray   <= wgray_next;
      full_q  <= (wgray_next == full_cmp);
      afull_q <= (level_next >= AfLevel);
      level_q <= level_next;
      // A dropped write sets the flag even when a clear arrives with it.
      ovf_q   <= (bus.winc & full_q) | (ovf_q & ~bus.wovf_clr);
    end
  end

  assign bus.w_addr       = wbin[AW-1:0];
  assign bus.wclken       = wclken_i;
  assign bus.wptr         = wgray;
  assign bus.wfull        = full_q;
  assign bus.walmost_full = afull_q;
  assign bus.wlevel       = level_q;
  assign bus.woverflow    = ovf_q;
endmodule
